// File: rtl/bfp_pkg.sv
// Shared FP32 field constants and response types for the block-floating-point DPU scheduler.
package bfp_pkg;

   localparam int BIT     = 32;
   localparam int FPM     = 23;
   localparam int EXP     = 8;
   localparam int RSP_IDW = 2;

   typedef logic [BIT-1:0] fp_t;

   typedef struct packed {
      logic [RSP_IDW-1:0] id;
      fp_t                data;
   } rsp_t;

endpackage

// File: rtl/bfp_sync_fifo.sv
// Synchronous FIFO with occupancy count; simultaneous push and pop leaves the count unchanged.
module bfp_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_push,
   input  logic [W-1:0]                 i_data,
   input  logic                         i_pop,
   output logic [W-1:0]                 o_data,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_count;
   logic          w_full;
   logic          w_push;
   logic          w_pop;

   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_pop   = i_pop && (r_count != '0);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push  = i_push && (!w_full || w_pop);

   assign o_data  = r_mem[r_rd];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= wrap_inc(r_wr);
         end
         if (w_pop) begin
            r_rd <= wrap_inc(r_rd);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/bfp_dpu_sched.sv
// Round-robin sharing of one fixed-latency, non-stallable DPU among R requesters,
// with credit flow control so every DPU result has a slot in the result FIFO.
module bfp_dpu_sched
   import bfp_pkg::*;
#(
   parameter int R     = 4,
   parameter int V     = 4,
   parameter int BIT   = 32,
   parameter int DEPTH = 8,
   parameter int IDW   = $clog2(R)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [R-1:0]                req_valid,
   input  logic [R-1:0][V-1:0][BIT-1:0] req_a,
   input  logic [R-1:0][V-1:0][BIT-1:0] req_b,
   output logic [R-1:0]                req_ready,
   output logic [V-1:0][BIT-1:0]       dpu_vector,
   output logic [V-1:0][BIT-1:0]       dpu_vector2,
   output logic                        dpu_valid,
   input  logic                        dpu_valid_out,
   input  logic [BIT-1:0]              dpu_outFP,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [IDW-1:0]              rsp_id,
   output logic [BIT-1:0]              rsp_data,
   output logic                        err
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = CW + 1;
   localparam int RW = IDW + BIT;

   logic [IDW-1:0]        r_ptr;
   logic [V-1:0][BIT-1:0] r_vec_a;
   logic [V-1:0][BIT-1:0] r_vec_b;
   logic                  r_dpu_valid;
   logic                  r_err;

   logic                  w_found;
   logic [IDW-1:0]        w_winner;
   logic [IDW-1:0]        w_ptr_next;
   logic                  w_credit_ok;
   logic                  w_fire;
   logic                  w_res_push;
   logic                  w_rsp_pop;
   logic                  w_tag_empty;
   logic                  w_res_empty;
   logic [IDW-1:0]        w_tag_head;
   logic [CW-1:0]         w_tag_count;
   logic [CW-1:0]         w_res_count;
   logic [OW-1:0]         w_occ;
   logic [RW-1:0]         w_res_head;

   // An issued pair counts once in the tag FIFO and once more while dpu_valid is high.
   assign w_occ       = OW'(w_tag_count) + OW'(w_res_count) + OW'(r_dpu_valid);
   assign w_credit_ok = (w_occ < OW'(DEPTH));

   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = 0; k < R; k++) begin
         if (!w_found && req_valid[(int'(r_ptr) + k) % R]) begin
            w_found  = 1'b1;
            w_winner = IDW'((int'(r_ptr) + k) % R);
         end
      end
   end

   assign w_fire     = w_found && w_credit_ok && reset;
   assign req_ready  = w_fire ? (R'(1) << w_winner) : '0;
   assign w_ptr_next = (w_winner == IDW'(R - 1)) ? '0 : w_winner + IDW'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr       <= '0;
         r_vec_a     <= '0;
         r_vec_b     <= '0;
         r_dpu_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_dpu_valid <= w_fire;
         if (w_fire) begin
            r_vec_a <= req_a[w_winner];
            r_vec_b <= req_b[w_winner];
            r_ptr   <= w_ptr_next;
         end
         if (dpu_valid_out && w_tag_empty) begin
            r_err <= 1'b1;
         end
      end
   end

   // A result with no outstanding tag is dropped rather than given a bogus ID.
   assign w_res_push = dpu_valid_out && !w_tag_empty;
   assign w_rsp_pop  = rsp_valid && rsp_ready;

   bfp_sync_fifo #(
      .W     (IDW),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_push  (w_fire),
      .i_data  (w_winner),
      .i_pop   (w_res_push),
      .o_data  (w_tag_head),
      .o_empty (w_tag_empty),
      .o_count (w_tag_count)
   );

   bfp_sync_fifo #(
      .W     (RW),
      .DEPTH (DEPTH)
   ) u_res_fifo (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_push  (w_res_push),
      .i_data  ({w_tag_head, dpu_outFP}),
      .i_pop   (w_rsp_pop),
      .o_data  (w_res_head),
      .o_empty (w_res_empty),
      .o_count (w_res_count)
   );

   assign dpu_vector  = r_vec_a;
   assign dpu_vector2 = r_vec_b;
   assign dpu_valid   = r_dpu_valid;
   assign err         = r_err;
   assign rsp_valid   = !w_res_empty;
   assign rsp_id      = w_res_head[BIT +: IDW];
   assign rsp_data    = w_res_head[BIT-1:0];

endmodule
